// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, default widths and the byte-select state.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned OPC_W      = 3;

    typedef enum logic [OPC_W-1:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STA = 3'b110,
        JMP = 3'b111
    } opcode_t;

    // Which half of the instruction the next captured byte fills.
    typedef enum logic {
        BYTE_HIGH = 1'b0,
        BYTE_LOW  = 1'b1
    } byte_sel_t;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Control/data bundle between the CPU controller (master) and the fetch unit (slave).
interface cpu_fetch_unit_if #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W_DEF,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W_DEF
);
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              halt;
    logic              fetch;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic              ir_valid;
    logic              pc_overflow;

    modport master (
        output data_in, rd, load_ir, inc_pc, load_pc, halt, fetch,
        input  opcode, ir_addr, pc, addr, ir_valid, pc_overflow
    );

    modport slave (
        input  data_in, rd, load_ir, inc_pc, load_pc, halt, fetch,
        output opcode, ir_addr, pc, addr, ir_valid, pc_overflow
    );
endinterface

// File: rtl/cpu_pc_counter.sv
// Program counter with halt > load > increment priority.
// Optional sticky wrap trap enabled by CPU_FETCH_PC_WRAP_TRAP_EN.
module cpu_pc_counter #(
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              load_pc,
    input  logic              inc_pc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_overflow
);
    localparam logic [ADDR_W-1:0] PC_MAX  = '1;
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_next;

`ifdef CPU_FETCH_PC_WRAP_TRAP_EN
    logic ovf;
    logic ovf_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= PC_INIT;
            ovf <= 1'b0;
        end else begin
            pc  <= pc_next;
            ovf <= ovf_next;
        end
    end

    // Increment at the top of memory saturates and raises the sticky trap.
    always_comb begin
        pc_next  = pc;
        ovf_next = ovf;
        if (!halt) begin
            if (load_pc) begin
                pc_next = load_val;
            end else if (inc_pc && !ovf) begin
                if (pc == PC_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    pc_next = pc + ADDR_W'(1);
                end
            end
        end
    end

    assign pc_overflow = ovf;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_INIT;
        end else begin
            pc <= pc_next;
        end
    end

    // Plain modulo-2^ADDR_W increment.
    always_comb begin
        pc_next = pc;
        if (!halt) begin
            if (load_pc) begin
                pc_next = load_val;
            end else if (inc_pc) begin
                pc_next = pc + ADDR_W'(1);
            end
        end
    end

    assign pc_overflow = 1'b0;
`endif

endmodule

// File: rtl/cpu_fetch_unit.sv
// Fetch unit: assembles 16-bit instructions from two byte reads, owns the PC and the address mux.
// Optional PC wrap trap: CPU_FETCH_PC_WRAP_TRAP_EN (see cpu_pc_counter).
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input logic             clk,
    input logic             rst,
    cpu_fetch_unit_if.slave bus
);
    localparam int unsigned IR_W = 2 * DATA_W;

    byte_sel_t         state;
    byte_sel_t         state_next;
    logic [IR_W-1:0]   ir;
    logic [IR_W-1:0]   ir_next;
    logic              ir_valid;
    logic              ir_valid_next;
    logic              fetch_q;
    logic              capture;
    logic              abort;
    logic [ADDR_W-1:0] pc;
    logic              pc_overflow;

    assign capture = bus.load_ir & bus.rd;
    assign abort   = fetch_q & ~bus.fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BYTE_HIGH;
            ir       <= '0;
            ir_valid <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            state    <= state_next;
            ir       <= ir_next;
            ir_valid <= ir_valid_next;
            fetch_q  <= bus.fetch;
        end
    end

    // Byte assembly; halt freezes the IR and the byte selector.
    always_comb begin
        state_next    = state;
        ir_next       = ir;
        ir_valid_next = ir_valid;
        if (!bus.halt) begin
            case (state)
                BYTE_HIGH: begin
                    if (capture) begin
                        ir_next[IR_W-1:DATA_W] = bus.data_in;
                        ir_valid_next          = 1'b0;
                        state_next             = BYTE_LOW;
                    end
                end
                BYTE_LOW: begin
                    if (abort) begin
                        ir_valid_next = 1'b0;
                        state_next    = BYTE_HIGH;
                    end else if (capture) begin
                        ir_next[DATA_W-1:0] = bus.data_in;
                        ir_valid_next       = 1'b1;
                        state_next          = BYTE_HIGH;
                    end
                end
                default: state_next = BYTE_HIGH;
            endcase
        end
    end

    cpu_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .halt        (bus.halt),
        .load_pc     (bus.load_pc),
        .inc_pc      (bus.inc_pc),
        .load_val    (ir[ADDR_W-1:0]),
        .pc          (pc),
        .pc_overflow (pc_overflow)
    );

    assign bus.opcode      = ir[IR_W-1 -: 3];
    assign bus.ir_addr     = ir[ADDR_W-1:0];
    assign bus.ir_valid    = ir_valid;
    assign bus.pc          = pc;
    assign bus.pc_overflow = pc_overflow;
    assign bus.addr        = bus.fetch ? pc : ir[ADDR_W-1:0];

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed steps then random cycles against a behavioural model.
module tb_cpu_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    cpu_fetch_unit_if #(.DATA_W(8), .ADDR_W(13)) bus ();

    cpu_fetch_unit #(.DATA_W(8), .ADDR_W(13), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: PC as integer mod 8192, IR as a 16-bit word, next-byte flag.
    int        m_pc;
    int        m_ir;
    bit        m_valid;
    bit        m_want_high;
    bit        m_fetch_prev;
    bit        m_ovf;

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_valid = 0; m_want_high = 1; m_fetch_prev = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        int old_ir_addr;
        old_ir_addr = m_ir % 8192;
        if (!bus.halt) begin
            if (!m_want_high && m_fetch_prev && !bus.fetch) begin
                m_want_high = 1;
                m_valid     = 0;
            end else if (bus.load_ir && bus.rd) begin
                if (m_want_high) begin
                    m_ir        = int'(bus.data_in) * 256 + (m_ir % 256);
                    m_valid     = 0;
                    m_want_high = 0;
                end else begin
                    m_ir        = (m_ir / 256) * 256 + int'(bus.data_in);
                    m_valid     = 1;
                    m_want_high = 1;
                end
            end
            if (bus.load_pc) begin
                m_pc = old_ir_addr;
            end else if (bus.inc_pc) begin
`ifdef CPU_FETCH_PC_WRAP_TRAP_EN
                if (!m_ovf) begin
                    if (m_pc == 8191) m_ovf = 1;
                    else m_pc = m_pc + 1;
                end
`else
                m_pc = (m_pc + 1) % 8192;
`endif
            end
        end
        m_fetch_prev = bus.fetch;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("pc",       16'(bus.pc),       16'(m_pc));
        chk("ir",       {bus.opcode, bus.ir_addr}, 16'(m_ir));
        chk("ir_valid", 16'(bus.ir_valid), 16'(m_valid));
        chk("pc_ovf",   16'(bus.pc_overflow), 16'(m_ovf));
    endtask

    // One controller cycle: drive at negedge, check addr mux, then check state after posedge.
    task automatic cyc(input logic r, input logic li, input logic ip, input logic lp,
                       input logic h, input logic f, input logic [7:0] d);
        @(negedge clk);
        bus.rd = r; bus.load_ir = li; bus.inc_pc = ip; bus.load_pc = lp;
        bus.halt = h; bus.fetch = f; bus.data_in = d;
        #1;
        chk("addr", 16'(bus.addr), f ? 16'(m_pc) : 16'(m_ir % 8192));
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rd = 0; bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0;
        bus.halt = 0; bus.fetch = 0; bus.data_in = '0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.rd = 0; bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0;
        bus.halt = 0; bus.fetch = 0; bus.data_in = '0;
        model_reset();

        do_reset();
        chk("reset_pc",     16'(bus.pc), 16'h0000);
        chk("reset_opcode", 16'(bus.opcode), 16'(3'b000));

        // Fetch A0 05 -> LDA 0x0005
        cyc(1, 1, 0, 0, 0, 1, 8'hA0);
        chk("hi_valid", 16'(bus.ir_valid), 16'h0);
        cyc(1, 1, 0, 0, 0, 1, 8'h05);
        chk("lda_opcode",  16'(bus.opcode), 16'(3'b101));
        chk("lda_ir_addr", 16'(bus.ir_addr), 16'h0005);
        chk("lda_valid",   16'(bus.ir_valid), 16'h1);

        // Load PC with 0x0010, then second byte captured together with inc_pc.
        cyc(1, 1, 0, 0, 0, 1, 8'h00);
        cyc(1, 1, 0, 0, 0, 1, 8'h10);
        cyc(0, 0, 0, 1, 0, 1, 8'h00);
        chk("pc_0010", 16'(bus.pc), 16'h0010);
        cyc(1, 1, 0, 0, 0, 1, 8'h20);
        cyc(1, 1, 1, 0, 0, 1, 8'h33);
        chk("inc_pc_0011", 16'(bus.pc), 16'h0011);
        chk("inc_ir",      {bus.opcode, bus.ir_addr}, 16'h2033);

        // JMP 0x0123 with load_pc and inc_pc together.
        cyc(1, 1, 0, 0, 0, 1, 8'hE1);
        cyc(1, 1, 0, 0, 0, 1, 8'h23);
        cyc(0, 0, 1, 1, 0, 1, 8'h00);
        chk("jmp_pc", 16'(bus.pc), 16'h0123);

        // Halt for three cycles with everything else asserted.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1, 0, 1, 1, 8'h5A);
            chk("halt_pc", 16'(bus.pc), 16'h0123);
            chk("halt_ir", {bus.opcode, bus.ir_addr}, 16'hE123);
        end
        cyc(1, 1, 1, 0, 0, 1, 8'h5A);
        chk("unhalt_pc", 16'(bus.pc), 16'h0124);
        chk("unhalt_valid", 16'(bus.ir_valid), 16'h0);

        // Reset after high byte only; next capture goes to the high byte.
        do_reset();
        cyc(1, 1, 0, 0, 0, 1, 8'h77);
        do_reset();
        chk("midrst_ir", {bus.opcode, bus.ir_addr}, 16'h0000);
        chk("midrst_valid", 16'(bus.ir_valid), 16'h0);
        cyc(1, 1, 0, 0, 0, 1, 8'h12);
        cyc(1, 1, 0, 0, 0, 1, 8'h34);
        chk("post_rst_ir", {bus.opcode, bus.ir_addr}, 16'h1234);

        // Aborted fetch: fetch drops while waiting for the low byte.
        cyc(1, 1, 0, 0, 0, 1, 8'h9C);
        cyc(1, 1, 0, 0, 0, 0, 8'h44);
        chk("abort_valid", 16'(bus.ir_valid), 16'h0);
        cyc(1, 1, 0, 0, 0, 1, 8'h66);
        chk("abort_hi", 16'(bus.opcode), 16'(3'b011));

        // Top-of-memory increment.
        do_reset();
        cyc(1, 1, 0, 0, 0, 1, 8'hFF);
        cyc(1, 1, 0, 0, 0, 1, 8'hFF);
        cyc(0, 0, 0, 1, 0, 1, 8'h00);
        chk("pc_max", 16'(bus.pc), 16'h1FFF);
        cyc(0, 0, 1, 0, 0, 1, 8'h00);
`ifdef CPU_FETCH_PC_WRAP_TRAP_EN
        chk("wrap_pc",  16'(bus.pc), 16'h1FFF);
        chk("wrap_ovf", 16'(bus.pc_overflow), 16'h1);
`else
        chk("wrap_pc",  16'(bus.pc), 16'h0000);
        chk("wrap_ovf", 16'(bus.pc_overflow), 16'h0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 9) < 7), 8'($urandom));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
